// File: rtl/s2p_word_receiver.sv
// Serial-to-parallel word receiver: MSB-first deserialiser, transmit-offset removal,
// and a show-ahead receive FIFO with sticky overflow/underflow/framing flags.
module s2p_word_receiver #(
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_WIDTH = 11,
  parameter int NUM_LOOPS  = 3,
  parameter int ADD_MODE   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ser_valid,
  input  logic                             ser_first,
  input  logic                             ser_data,
  input  logic                             pop,
  input  logic                             clr_err,
  output logic [FIFO_WIDTH-1:0]            pop_data,
  output logic                             empty,
  output logic                             full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
  output logic                             overflow,
  output logic                             underflow,
  output logic                             frame_err
);

  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_WIDTH + 1);

  localparam logic [FIFO_WIDTH-1:0] OFFSET   = FIFO_WIDTH'(NUM_LOOPS);
  localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(FIFO_WIDTH - 1);
  localparam logic [LVL_W-1:0]      FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t                state, state_nxt;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_nxt;
  logic [FIFO_WIDTH-1:0] shift, shift_nxt;
  logic [FIFO_WIDTH-1:0] word_in;
  logic [FIFO_WIDTH-1:0] first_word;
  logic                  word_done;
  logic                  mid_first;

  assign word_in    = {shift[FIFO_WIDTH-2:0], ser_data};
  assign first_word = {{(FIFO_WIDTH-1){1'b0}}, ser_data};

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    word_done   = 1'b0;
    mid_first   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ser_valid && ser_first) begin
          state_nxt   = COLLECT;
          bit_cnt_nxt = CNT_W'(1);
          shift_nxt   = first_word;
        end
      end
      COLLECT: begin
        if (ser_valid) begin
          if (ser_first) begin
            // A new MSB mid-word restarts framing; the partial word is lost.
            mid_first   = 1'b1;
            bit_cnt_nxt = CNT_W'(1);
            shift_nxt   = first_word;
          end else if (bit_cnt == LAST_CNT) begin
            word_done   = 1'b1;
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
            shift_nxt   = '0;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
            shift_nxt   = word_in;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Offset correction stage (one word per completion, written to FIFO next edge)
  // ---------------------------------------------------------------------------
  logic                  stage_valid;
  logic [FIFO_WIDTH-1:0] stage_data;
  logic [FIFO_WIDTH-1:0] corrected;

  assign corrected = (ADD_MODE != 0) ? (word_in - OFFSET) : (word_in + OFFSET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
    end else begin
      stage_valid <= word_done;
      if (word_done) begin
        stage_data <= corrected;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO with full-depth occupancy counter
  // ---------------------------------------------------------------------------
  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr, rptr;
  logic                  do_pop;
  logic                  do_write;
  logic                  drop;

  assign empty    = (level == '0);
  assign full     = (level == FULL_LVL);
  assign do_pop   = pop && !empty;
  assign do_write = stage_valid && (!full || do_pop);
  assign drop     = stage_valid && full && !do_pop;
  assign pop_data = empty ? '0 : mem[rptr];

  // NOTE: the storage array is deliberately not reset; the occupancy counter
  // and pointers alone define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wptr] <= stage_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_write) begin
        wptr <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({do_write, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags; clear wins over a same-cycle set
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else if (clr_err) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
      if (mid_first) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_s2p_word_receiver.sv
// Directed bench for s2p_word_receiver: stimulus pushes expected corrected words
// into a scoreboard; a negedge monitor checks every accepted pop against it.
module tb_s2p_word_receiver;

  localparam int W    = 11;
  localparam int D    = 8;
  localparam int NL   = 3;
  localparam int AM   = 1;
  localparam int LW   = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          ser_valid;
  logic          ser_first;
  logic          ser_data;
  logic          pop;
  logic          clr_err;
  logic [W-1:0]  pop_data;
  logic          empty;
  logic          full;
  logic [LW-1:0] level;
  logic          overflow;
  logic          underflow;
  logic          frame_err;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [W-1:0]  sb [$];
  logic [W-1:0]  exp_w;

  always #5 clk = ~clk;

  s2p_word_receiver #(
    .FIFO_DEPTH (D),
    .FIFO_WIDTH (W),
    .NUM_LOOPS  (NL),
    .ADD_MODE   (AM)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ser_valid (ser_valid),
    .ser_first (ser_first),
    .ser_data  (ser_data),
    .pop       (pop),
    .clr_err   (clr_err),
    .pop_data  (pop_data),
    .empty     (empty),
    .full      (full),
    .level     (level),
    .overflow  (overflow),
    .underflow (underflow),
    .frame_err (frame_err)
  );

  function automatic logic [W-1:0] model_correct(input logic [W-1:0] w);
    return (AM != 0) ? (w - W'(NL)) : (w + W'(NL));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic first, input int gap);
    ser_valid = 1'b1;
    ser_first = first;
    ser_data  = b;
    tick();
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_data  = 1'b0;
    repeat (gap) tick();
  endtask

  // Returns right after the edge that samples the last bit (edge N).
  task automatic send_word(input logic [W-1:0] w, input bit store, input bit gaps);
    if (store) sb.push_back(model_correct(w));
    for (int i = W - 1; i >= 0; i--) begin
      send_bit(w[i], i == W - 1, (gaps && i > 0) ? (i % 3) : 0);
    end
  endtask

  task automatic do_pop();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  // Scoreboard monitor: every pop the DUT accepts must match the next expected word.
  always @(negedge clk) begin
    if (!rst && pop && !empty) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", pop_data);
      end else begin
        exp_w = sb.pop_front();
        check("pop_data", 32'(pop_data), 32'(exp_w));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    ser_valid = 1'b0;
    ser_first = 1'b0;
    ser_data  = 1'b0;
    pop       = 1'b0;
    clr_err   = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_pop_data", 32'(pop_data), 32'h0);
    check("rst_empty",    32'(empty),    32'h1);
    check("rst_full",     32'(full),     32'h0);
    check("rst_level",    32'(level),    32'h0);
    check("rst_flags",    {29'h0, overflow, underflow, frame_err}, 32'h0);

    // 1: 0x00A back-to-back -> 0x007, FIFO write one edge after the last bit
    send_word(11'h00A, 1'b1, 1'b0);
    check("t1_empty_at_N", 32'(empty), 32'h1);
    tick();
    check("t1_empty_at_N1", 32'(empty),    32'h0);
    check("t1_level",       32'(level),    32'h1);
    check("t1_pop_data",    32'(pop_data), 32'h007);
    do_pop();
    check("t1_empty_after_pop", 32'(empty), 32'h1);

    // 2: gapped stream, wrap-around correction
    send_word(11'h001, 1'b1, 1'b1);
    tick();
    check("t2_pop_data", 32'(pop_data), 32'h7FE);
    do_pop();
    send_word(11'h7FF, 1'b1, 1'b1);
    tick();
    check("t2b_pop_data", 32'(pop_data), 32'h7FC);
    do_pop();

    // 3: nine words without pop -> ninth dropped
    for (int i = 0; i < D; i++) send_word(W'(i * 37 + 20), 1'b1, 1'b0);
    tick();
    check("t3_full",     32'(full),     32'h1);
    check("t3_level",    32'(level),    32'h8);
    check("t3_overflow", 32'(overflow), 32'h0);
    check("t3_head",     32'(pop_data), 32'h011);
    send_word(11'h555, 1'b0, 1'b0);
    tick();
    check("t3_overflow_set", 32'(overflow), 32'h1);
    check("t3_level_held",   32'(level),    32'h8);
    pulse_clr();
    check("t3_overflow_clr", 32'(overflow), 32'h0);
    repeat (D) do_pop();
    check("t3_drained", 32'(empty), 32'h1);
    check("t3_sb_empty", 32'(sb.size()), 32'h0);

    // 4: pop coincides with the write into a full FIFO
    for (int i = 0; i < D; i++) send_word(W'(i * 101 + 7), 1'b1, 1'b0);
    tick();
    check("t4_full", 32'(full), 32'h1);
    send_word(11'h2AB, 1'b1, 1'b0);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    check("t4_level",    32'(level),    32'h8);
    check("t4_overflow", 32'(overflow), 32'h0);
    repeat (D) do_pop();
    check("t4_drained", 32'(empty), 32'h1);

    // 5: underflow, then clear wins over a same-cycle set
    do_pop();
    check("t5_underflow", 32'(underflow), 32'h1);
    check("t5_level",     32'(level),     32'h0);
    clr_err = 1'b1;
    pop     = 1'b1;
    tick();
    clr_err = 1'b0;
    pop     = 1'b0;
    check("t5_underflow_clr", 32'(underflow), 32'h0);

    // 6: stray IDLE bits ignored, restart after 5 bits -> frame_err, only 0x0FD stored
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 1);
    send_bit(1'b1, 1'b1, 0);
    send_bit(1'b0, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b0, 1'b0, 0);
    send_word(11'h100, 1'b1, 1'b0);
    check("t6_frame_err", 32'(frame_err), 32'h1);
    tick();
    check("t6_level",    32'(level),    32'h1);
    check("t6_pop_data", 32'(pop_data), 32'h0FD);
    do_pop();
    pulse_clr();
    check("t6_frame_err_clr", 32'(frame_err), 32'h0);

    // Reset mid-word with a stored word: everything back to reset values
    send_word(11'h333, 1'b1, 1'b0);
    tick();
    check("rw_level_before", 32'(level), 32'h1);
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0, 0);
    #2;
    rst = 1'b1;
    sb.delete();
    #2;
    check("rw_pop_data", 32'(pop_data), 32'h0);
    check("rw_empty",    32'(empty),    32'h1);
    check("rw_level",    32'(level),    32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0, 0);
    repeat (3) tick();
    check("rw_no_word",   32'(empty),     32'h1);
    check("rw_frame_err", 32'(frame_err), 32'h0);

    check("final_sb_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
